// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF     = 64;
    localparam int DATA_W_DEF     = 64;
    localparam int STARVE_MAX_DEF = 3;
    localparam int CNT_W_DEF      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_starve_counter.sv
// Saturating count of data grants made while fetch was waiting.
module arb_starve_counter #(
    parameter int CNT_W      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !sat_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one variable-latency memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              proto_err
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_ready_q, dm_ready_d;
    logic              proto_err_q, proto_err_d;
    logic              if_hi_q, if_hi_d;
    logic              cnt_inc, cnt_clr, cnt_sat;
    logic              dm_win, if_win;
    logic              unused_if_lsbs;

    // Byte offset within the fetched word is irrelevant; only bit 2 picks the half.
    assign unused_if_lsbs = ^if_addr[1:0];

    // Fetch wins over a pending data request only once the counter has saturated.
    assign dm_win = (dm_read | dm_write) & ~(if_req & cnt_sat);
    assign if_win = if_req & ~dm_win;

    arb_starve_counter #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .sat_o (cnt_sat)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dm_win)
                    state_d = BUSY_DM;
                else if (if_win)
                    state_d = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: if (mem_ack) state_d = DONE;
            DONE:             state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_hi_d     = if_hi_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        proto_err_d = proto_err_q | (dm_read & dm_write);
        unique case (state_q)
            IDLE: begin
                if (dm_win) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_inc     = if_req;
                end else if (if_win) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {if_addr[ADDR_W-1:3], 3'b000};
                    if_hi_d    = if_addr[2];
                    cnt_clr    = 1'b1;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = if_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    if_ready_d = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    dm_ready_d = 1'b1;
                    if (!mem_we_q)
                        dm_rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_ready_q  <= 1'b0;
            proto_err_q <= 1'b0;
            if_hi_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_ready_q  <= dm_ready_d;
            proto_err_q <= proto_err_d;
            if_hi_q     <= if_hi_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign proto_err = proto_err_q;

endmodule
